// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch redirect controller.
// Resolves the control-flow instruction in EX against its fetch prediction,
// holds EX while operands are still forwarding-pending, issues a registered
// valid/ready redirect to fetch, pulses the front-end flush, flags misaligned
// taken targets and keeps branch/mispredict statistics.
module branch_redirect_ctrl #(
  parameter int P_CNT_W  = 32,
  parameter int P_IALIGN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_exValid_1,
  input  logic               i_exIsCtrl_1,
  input  logic               i_opndReady_1,
  input  logic [31:0]        i_exPC_32,
  input  logic               i_isBranch_1,
  input  logic [31:0]        i_branchPC_32,
  input  logic               i_predTaken_1,
  input  logic [31:0]        i_predPC_32,
  input  logic               i_redirectReady_1,
  input  logic               i_flushExt_1,
  output logic               o_stallEX_1,
  output logic               o_flush_1,
  output logic               o_redirectValid_1,
  output logic [31:0]        o_redirectPC_32,
  output logic               o_misalignExc_1,
  output logic [31:0]        o_excPC_32,
  output logic [P_CNT_W-1:0] o_branchCnt_W,
  output logic [P_CNT_W-1:0] o_mispredCnt_W
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_OPND = 2'd1,
    S_REDIRECT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;
  logic                 misalign_q, misalign_d;
  logic [31:0]          exc_pc_q, exc_pc_d;
  logic [P_CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [P_CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic                 ctrl_in_ex;
  logic [31:0]          actual_pc;
  logic                 mispredict;
  logic                 target_unaligned;
  logic                 misaligned;

  // Resolve-time comparisons of the branch unit result against the prediction.
  assign ctrl_in_ex       = i_exValid_1 & i_exIsCtrl_1;
  assign actual_pc        = i_isBranch_1 ? i_branchPC_32 : (i_exPC_32 + 32'd4);
  assign mispredict       = (i_isBranch_1 != i_predTaken_1) |
                            (i_isBranch_1 & i_predTaken_1 & (i_branchPC_32 != i_predPC_32));
  assign target_unaligned = (P_IALIGN == 2) ? i_branchPC_32[0] : (|i_branchPC_32[1:0]);
  assign misaligned       = i_isBranch_1 & target_unaligned;

  // Stall is combinational so EX is held in the same cycle operands are late.
  assign o_stallEX_1 = ((state_q == S_WAIT_OPND) & ~i_opndReady_1) |
                       ((state_q == S_IDLE) & ctrl_in_ex & ~i_opndReady_1) |
                       (state_q == S_REDIRECT);

  // Next-state, redirect/exception launch and counter update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    misalign_d       = 1'b0;
    exc_pc_d         = exc_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    if (i_flushExt_1) begin
      // A later-stage flush wins over everything, including a same-cycle resolve.
      state_d          = S_IDLE;
      redirect_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_WAIT_OPND: begin
          if (ctrl_in_ex && i_opndReady_1) begin
            branch_cnt_d = branch_cnt_q + P_CNT_W'(1);
            state_d      = S_IDLE;
            if (misaligned) begin
              misalign_d    = 1'b1;
              exc_pc_d      = i_exPC_32;
              flush_d       = 1'b1;
              mispred_cnt_d = mispred_cnt_q + P_CNT_W'(1);
            end else if (mispredict) begin
              redirect_valid_d = 1'b1;
              redirect_pc_d    = actual_pc;
              flush_d          = 1'b1;
              mispred_cnt_d    = mispred_cnt_q + P_CNT_W'(1);
              state_d          = S_REDIRECT;
            end
          end else if (ctrl_in_ex) begin
            state_d = S_WAIT_OPND;
          end else begin
            // Instruction left EX (or is not control flow): abandon without counting.
            state_d = S_IDLE;
          end
        end
        S_REDIRECT: begin
          if (i_redirectReady_1) begin
            redirect_valid_d = 1'b0;
            state_d          = S_IDLE;
          end
        end
        default: begin
          state_d          = S_IDLE;
          redirect_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= S_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      exc_pc_q         <= 32'd0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
      exc_pc_q         <= exc_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign o_flush_1         = flush_q;
  assign o_redirectValid_1 = redirect_valid_q;
  assign o_redirectPC_32   = redirect_pc_q;
  assign o_misalignExc_1   = misalign_q;
  assign o_excPC_32        = exc_pc_q;
  assign o_branchCnt_W     = branch_cnt_q;
  assign o_mispredCnt_W    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios followed by
// randomized traffic, checked against a behavioural model of the rules.
module tb_branch_redirect_ctrl;

  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_exValid_1 = 1'b0, i_exIsCtrl_1 = 1'b0, i_opndReady_1 = 1'b0;
  logic [31:0]   i_exPC_32 = '0, i_branchPC_32 = '0, i_predPC_32 = '0;
  logic          i_isBranch_1 = 1'b0, i_predTaken_1 = 1'b0;
  logic          i_redirectReady_1 = 1'b0, i_flushExt_1 = 1'b0;

  logic          o_stallEX_1, o_flush_1, o_redirectValid_1, o_misalignExc_1;
  logic [31:0]   o_redirectPC_32, o_excPC_32;
  logic [CW-1:0] o_branchCnt_W, o_mispredCnt_W;

  logic          a2_stall, a2_flush, a2_rv, a2_exc;
  logic [31:0]   a2_rpc, a2_excpc, a2_bcnt, a2_mcnt;

  branch_redirect_ctrl #(.P_CNT_W(CW), .P_IALIGN(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exValid_1(i_exValid_1), .i_exIsCtrl_1(i_exIsCtrl_1), .i_opndReady_1(i_opndReady_1),
    .i_exPC_32(i_exPC_32), .i_isBranch_1(i_isBranch_1), .i_branchPC_32(i_branchPC_32),
    .i_predTaken_1(i_predTaken_1), .i_predPC_32(i_predPC_32),
    .i_redirectReady_1(i_redirectReady_1), .i_flushExt_1(i_flushExt_1),
    .o_stallEX_1(o_stallEX_1), .o_flush_1(o_flush_1),
    .o_redirectValid_1(o_redirectValid_1), .o_redirectPC_32(o_redirectPC_32),
    .o_misalignExc_1(o_misalignExc_1), .o_excPC_32(o_excPC_32),
    .o_branchCnt_W(o_branchCnt_W), .o_mispredCnt_W(o_mispredCnt_W)
  );

  // Half-word aligned variant, only examined in the misaligned-target scenario.
  branch_redirect_ctrl #(.P_CNT_W(32), .P_IALIGN(2)) dut_a2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exValid_1(i_exValid_1), .i_exIsCtrl_1(i_exIsCtrl_1), .i_opndReady_1(i_opndReady_1),
    .i_exPC_32(i_exPC_32), .i_isBranch_1(i_isBranch_1), .i_branchPC_32(i_branchPC_32),
    .i_predTaken_1(i_predTaken_1), .i_predPC_32(i_predPC_32),
    .i_redirectReady_1(i_redirectReady_1), .i_flushExt_1(i_flushExt_1),
    .o_stallEX_1(a2_stall), .o_flush_1(a2_flush),
    .o_redirectValid_1(a2_rv), .o_redirectPC_32(a2_rpc),
    .o_misalignExc_1(a2_exc), .o_excPC_32(a2_excpc),
    .o_branchCnt_W(a2_bcnt), .o_mispredCnt_W(a2_mcnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          stall, flush, rv, exc;
    logic [31:0]   rpc, excpc;
    logic [CW-1:0] bcnt, mcnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] exc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the block has promised so far, in plain terms.
  bit          m_pending;   // a redirect is outstanding at fetch
  bit          m_waiting;   // a control instruction is parked waiting for operands
  bit          m_rv, m_flush, m_exc;
  logic [31:0] m_rpc, m_excpc;
  int unsigned m_bcnt, m_mcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  // Drive one cycle of inputs, record what this cycle must show, advance the model.
  task automatic step(input bit v, input bit c, input bit o, input logic [31:0] pc,
                      input bit br, input logic [31:0] bpc, input bit pt,
                      input logic [31:0] ppc, input bit rdy, input bit fx);
    exp_t        e;
    bit          mis, misp;
    logic [31:0] act;
    @(posedge i_clk);
    #1;
    i_exValid_1 = v; i_exIsCtrl_1 = c; i_opndReady_1 = o; i_exPC_32 = pc;
    i_isBranch_1 = br; i_branchPC_32 = bpc; i_predTaken_1 = pt; i_predPC_32 = ppc;
    i_redirectReady_1 = rdy; i_flushExt_1 = fx;

    e.stall = m_pending | (m_waiting & !o) | (!m_waiting & !m_pending & v & c & !o);
    e.flush = m_flush; e.rv = m_rv; e.rpc = m_rpc;
    e.exc = m_exc; e.excpc = m_excpc;
    e.bcnt = CW'(m_bcnt); e.mcnt = CW'(m_mcnt);
    exp_q.push_back(e);

    m_flush = 0;
    m_exc   = 0;
    if (fx) begin
      // Cancelled redirect never handshakes unless fetch was ready right now.
      if (m_pending && !rdy) void'(redir_q.pop_back());
      m_pending = 0; m_waiting = 0; m_rv = 0;
    end else if (m_pending) begin
      if (rdy) begin m_pending = 0; m_rv = 0; end
    end else if (v && c && o) begin
      m_waiting = 0;
      m_bcnt = (m_bcnt + 1) % (1 << CW);
      act  = br ? bpc : pc + 32'd4;
      mis  = br && (bpc % 4 != 0);
      misp = (br != pt) || (br && pt && bpc != ppc);
      if (mis) begin
        m_exc = 1; m_excpc = pc; m_flush = 1;
        m_mcnt = (m_mcnt + 1) % (1 << CW);
        exc_q.push_back(pc);
      end else if (misp) begin
        m_rv = 1; m_rpc = act; m_flush = 1; m_pending = 1;
        m_mcnt = (m_mcnt + 1) % (1 << CW);
        redir_q.push_back(act);
      end
    end else begin
      m_waiting = v && c;
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, rdy, 0);
  endtask

  // Monitor: compare each cycle's outputs and each completed transaction.
  initial begin
    exp_t e;
    logic [31:0] t;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",      o_stallEX_1,       e.stall);
        check("flush",      o_flush_1,         e.flush);
        check("redir_vld",  o_redirectValid_1, e.rv);
        check("redir_pc",   o_redirectPC_32,   e.rpc);
        check("misalign",   o_misalignExc_1,   e.exc);
        check("exc_pc",     o_excPC_32,        e.excpc);
        check("branch_cnt", o_branchCnt_W,     e.bcnt);
        check("mispr_cnt",  o_mispredCnt_W,    e.mcnt);
      end
      if (o_redirectValid_1 && i_redirectReady_1) begin
        if (redir_q.size() == 0) fail_now("redir_unexpected");
        else begin t = redir_q.pop_front(); check("redir_xfer_pc", o_redirectPC_32, t); end
      end
      if (o_misalignExc_1) begin
        if (exc_q.size() == 0) fail_now("exc_unexpected");
        else begin t = exc_q.pop_front(); check("exc_xfer_pc", o_excPC_32, t); end
      end
    end
  end

  initial begin
    #2;
    check("rst_stall", o_stallEX_1, 0);
    check("rst_flush", o_flush_1, 0);
    check("rst_rv",    o_redirectValid_1, 0);
    check("rst_rpc",   o_redirectPC_32, 0);
    check("rst_exc",   o_misalignExc_1, 0);
    check("rst_excpc", o_excPC_32, 0);
    check("rst_bcnt",  o_branchCnt_W, 0);
    check("rst_mcnt",  o_mispredCnt_W, 0);
    #20;
    i_rst_n = 1'b1;

    // BEQ mispredicted not-taken, fetch ready at once.
    step(1, 1, 1, 32'h100, 1, 32'h140, 0, 32'h0, 1, 0);
    idle(1);
    check("beq_rv",    o_redirectValid_1, 1);
    check("beq_pc",    o_redirectPC_32, 32'h140);
    check("beq_flush", o_flush_1, 1);
    check("beq_bcnt",  o_branchCnt_W, 1);
    check("beq_mcnt",  o_mispredCnt_W, 1);
    idle(1);
    check("beq_rv_drop",    o_redirectValid_1, 0);
    check("beq_flush_drop", o_flush_1, 0);

    // Same branch with fetch back-pressure for three cycles.
    step(1, 1, 1, 32'h100, 1, 32'h140, 0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      check("bp_rv_hold",    o_redirectValid_1, 1);
      check("bp_pc_hold",    o_redirectPC_32, 32'h140);
      check("bp_stall",      o_stallEX_1, 1);
    end
    idle(1);
    check("bp_rv_hs", o_redirectValid_1, 1);
    idle(0);
    check("bp_rv_drop", o_redirectValid_1, 0);
    check("bp_stall_drop", o_stallEX_1, 0);

    // JAL correctly predicted.
    step(1, 1, 1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 0);
    idle(1);
    check("jal_rv",    o_redirectValid_1, 0);
    check("jal_flush", o_flush_1, 0);
    check("jal_bcnt",  o_branchCnt_W, 3);
    check("jal_mcnt",  o_mispredCnt_W, 2);

    // BNE waits two cycles for operands, predicted taken but falls through.
    step(1, 1, 0, 32'h80, 0, 32'h0, 1, 32'h90, 1, 0);
    check("bne_stall0", o_stallEX_1, 1);
    step(1, 1, 0, 32'h80, 0, 32'h0, 1, 32'h90, 1, 0);
    check("bne_stall1", o_stallEX_1, 1);
    step(1, 1, 1, 32'h80, 0, 32'h0, 1, 32'h90, 1, 0);
    check("bne_stall_rel", o_stallEX_1, 0);
    idle(1);
    check("bne_rv",   o_redirectValid_1, 1);
    check("bne_pc",   o_redirectPC_32, 32'h84);
    check("bne_bcnt", o_branchCnt_W, 4);
    check("bne_mcnt", o_mispredCnt_W, 3);
    idle(1);

    // JALR to a half-word aligned target.
    step(1, 1, 1, 32'h400, 1, 32'h1002, 0, 32'h0, 1, 0);
    idle(1);
    check("jalr_exc",      o_misalignExc_1, 1);
    check("jalr_excpc",    o_excPC_32, 32'h400);
    check("jalr_flush",    o_flush_1, 1);
    check("jalr_rv",       o_redirectValid_1, 0);
    check("jalr_a2_rv",    a2_rv, 1);
    check("jalr_a2_pc",    a2_rpc, 32'h1002);
    check("jalr_a2_exc",   a2_exc, 0);
    idle(1);
    check("jalr_exc_drop", o_misalignExc_1, 0);
    check("jalr_a2_drop",  a2_rv, 0);

    // External flush while a redirect is outstanding.
    step(1, 1, 1, 32'h100, 1, 32'h140, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    idle(0);
    check("fx_redir_rv",    o_redirectValid_1, 0);
    check("fx_redir_stall", o_stallEX_1, 0);
    check("fx_redir_bcnt",  o_branchCnt_W, 6);
    // External flush in the resolve cycle itself.
    step(1, 1, 1, 32'h100, 1, 32'h140, 0, 32'h0, 1, 1);
    idle(1);
    check("fx_res_rv",    o_redirectValid_1, 0);
    check("fx_res_flush", o_flush_1, 0);
    check("fx_res_bcnt",  o_branchCnt_W, 6);
    check("fx_res_mcnt",  o_mispredCnt_W, 5);

    // Correct predictions up to the counter wrap.
    for (int i = 0; i < 250; i++) step(1, 1, 1, 32'h40 + 32'(i * 4), 0, 32'h0, 0, 32'h0, 1, 0);
    idle(1);
    check("bcnt_wrap", o_branchCnt_W, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, bpc, ppc;
      pc  = $urandom & 32'hFFFF_FFFC;
      bpc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ppc = ($urandom_range(0, 1) == 0) ? bpc : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           pc, $urandom_range(0, 1) == 1, bpc, $urandom_range(0, 1) == 1, ppc,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    repeat (4) idle(1);
    @(negedge i_clk);
    @(negedge i_clk);
    check("sb_cycles_left", exp_q.size(), 0);
    check("sb_redir_left",  redir_q.size(), 0);
    check("sb_exc_left",    exc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
